// File: rtl/shifter_palette.sv
// shifter_palette
// Colour look-up stage behind the bitplane serialiser. It maps the 4-bit
// colour index through a 16-entry, 12-bit CPU palette and registers 4-bit
// R/G/B plus a monochrome bit. It also serves the CPU palette register file.
//
// Ports
//   clk32        : 32 MHz clock, the only clock
//   reset        : asynchronous, active-high reset
//   pixClkEn     : pixel clock enable; advances the S1/S2 pixel pipeline
//   rez          : resolution; rez[1] selects mono (11 behaves as 10)
//   color_index  : palette index from the serialiser
//   BLANK_n      : 0 = force black; delayed along with color_index
//   cs, rw       : CPU palette select (active high) and direction (1 = read)
//   addr         : palette entry (CPU A[4:1])
//   din / dout   : CPU write data / registered CPU read data
//   R, G, B      : pixel colour, 4 bits per channel
//   mono_out     : monochrome pixel, 1 = white
module shifter_palette #(
    parameter int STE = 1
) (
    input  logic        clk32,
    input  logic        reset,
    input  logic        pixClkEn,
    input  logic [1:0]  rez,
    input  logic [3:0]  color_index,
    input  logic        BLANK_n,
    input  logic        cs,
    input  logic        rw,
    input  logic [3:0]  addr,
    input  logic [15:0] din,
    output logic [15:0] dout,
    output logic [3:0]  R,
    output logic [3:0]  G,
    output logic [3:0]  B,
    output logic        mono_out
);

    // The ST format has no channel LSB: nibble bit 3 is never stored.
    localparam logic [11:0] STORE_MASK = (STE != 0) ? 12'hFFF : 12'h777;

    // Nibble bit 3 is the STE LSB. The new LSB replicates a real bit so that
    // full scale still reaches 4'hF.
    function automatic logic [3:0] expand(input logic [3:0] nib);
        return (STE != 0) ? {nib[2:0], nib[3]} : {nib[2:0], nib[2]};
    endfunction

    logic [15:0][11:0] pal;
    logic              wr_req;
    logic              wr_prev;
    logic [3:0]        idx1;
    logic              vis1;
    logic              mono1;
    logic [11:0]       ent;
    logic              mono_bit;
    logic [12:0]       pix_next;   // {R, G, B, mono}
    logic              unused_bits;

    assign unused_bits = ^{din[15:12], rez[0]};

    // A write fires on the rising edge of cs & ~rw only. wr_prev resets
    // to 1, so a strobe that is already high when reset is released is
    // ignored until it drops and rises again.
    assign wr_req = cs & ~rw;

    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            pal     <= '0;
            wr_prev <= 1'b1;
        end else begin
            wr_prev <= wr_req;
            if (wr_req && !wr_prev)
                pal[addr] <= din[11:0] & STORE_MASK;
        end
    end

    // This reads the pre-edge palette, so a same-cycle write returns old data.
    always_ff @(posedge clk32 or posedge reset) begin
        if (reset)
            dout <= 16'h0000;
        else if (cs && rw)
            dout <= {4'h0, pal[addr]};
        else
            dout <= 16'h0000;
    end

    // S1: sample the pixel attributes.
    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            idx1  <= 4'h0;
            vis1  <= 1'b0;
            mono1 <= 1'b0;
        end else if (pixClkEn) begin
            idx1  <= color_index;
            vis1  <= BLANK_n;
            mono1 <= rez[1];
        end
    end

    // S2 look-up. A write that commits on the same edge is not seen here,
    // so the pixel being loaded keeps the old colour.
    assign ent      = pal[idx1];
    assign mono_bit = idx1[0] ^ pal[0][0];

    always_comb begin
        pix_next = 13'h0;
        if (vis1) begin
            if (mono1)
                pix_next = mono_bit ? 13'h1FFF : 13'h0000;
            else
                pix_next = {expand(ent[11:8]), expand(ent[7:4]), expand(ent[3:0]), 1'b0};
        end
    end

    always_ff @(posedge clk32 or posedge reset) begin
        if (reset)
            {R, G, B, mono_out} <= 13'h0;
        else if (pixClkEn)
            {R, G, B, mono_out} <= pix_next;
    end

endmodule

// File: tb/tb_shifter_palette.sv
// Bench for shifter_palette. It drives an STE and an ST instance from shared
// stimulus and compares both against a queue/array reference model.
module tb_shifter_palette;

    logic        clk32 = 1'b0;
    logic        reset;
    logic        pixClkEn;
    logic [1:0]  rez;
    logic [3:0]  color_index;
    logic        BLANK_n;
    logic        cs;
    logic        rw;
    logic [3:0]  addr;
    logic [15:0] din;
    logic [15:0] dout1, dout0;
    logic [3:0]  r1, g1, b1, r0, g0, b0;
    logic        m1, m0;

    always #5 clk32 = ~clk32;

    shifter_palette #(.STE(1)) u_ste (
        .clk32(clk32), .reset(reset), .pixClkEn(pixClkEn), .rez(rez),
        .color_index(color_index), .BLANK_n(BLANK_n), .cs(cs), .rw(rw),
        .addr(addr), .din(din), .dout(dout1), .R(r1), .G(g1), .B(b1),
        .mono_out(m1));

    shifter_palette #(.STE(0)) u_st (
        .clk32(clk32), .reset(reset), .pixClkEn(pixClkEn), .rez(rez),
        .color_index(color_index), .BLANK_n(BLANK_n), .cs(cs), .rw(rw),
        .addr(addr), .din(din), .dout(dout0), .R(r0), .G(g0), .B(b0),
        .mono_out(m0));

    typedef struct packed {
        logic [3:0] idx;
        logic       vis;
        logic       mono;
    } pix_t;

    // Reference model state
    pix_t        pq[$];          // pixels sampled but not yet displayed
    logic [11:0] pal1[16];
    logic [11:0] pal0[16];
    logic [12:0] exp1, exp0;     // {R,G,B,mono}
    logic [15:0] edout1, edout0;
    logic        wprev;
    int          nvec = 0;
    int          nmis = 0;

    // The channel is 2*(low three bits) plus a replicated LSB.
    function automatic logic [3:0] chan(int ste, logic [3:0] n);
        int v;
        int lsb;
        lsb = (ste != 0) ? int'(n) / 8 : (int'(n) / 4) % 2;
        v = (int'(n) % 8) * 2 + lsb;
        return v[3:0];
    endfunction

    function automatic logic [12:0] look(int ste, logic [11:0] e, logic [11:0] e0, pix_t p);
        if (!p.vis) return 13'h0;
        if (p.mono) return (p.idx[0] != e0[0]) ? 13'h1FFF : 13'h0;
        return {chan(ste, e[11:8]), chan(ste, e[7:4]), chan(ste, e[3:0]), 1'b0};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nmis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        pq.delete();
        for (int i = 0; i < 16; i++) begin
            pal1[i] = 12'h0;
            pal0[i] = 12'h0;
        end
        exp1 = 13'h0; exp0 = 13'h0;
        edout1 = 16'h0; edout0 = 16'h0;
        wprev = 1'b1;
    endtask

    // Called at a negedge. The task drives the inputs, predicts from the
    // pre-edge model, runs one clock, and checks both instances.
    task automatic step(logic en, logic [1:0] rz, logic [3:0] ci, logic bl,
                        logic c, logic r, logic [3:0] a, logic [15:0] d);
        pix_t p;
        pixClkEn = en; rez = rz; color_index = ci; BLANK_n = bl;
        cs = c; rw = r; addr = a; din = d;
        edout1 = (c && r) ? {4'h0, pal1[a]} : 16'h0;
        edout0 = (c && r) ? {4'h0, pal0[a]} : 16'h0;
        if (en) begin
            if (pq.size() > 0) begin
                p = pq.pop_front();
                exp1 = look(1, pal1[p.idx], pal1[0], p);
                exp0 = look(0, pal0[p.idx], pal0[0], p);
            end else begin
                exp1 = 13'h0;
                exp0 = 13'h0;
            end
            p.idx = ci; p.vis = bl; p.mono = rz[1];
            pq.push_back(p);
        end
        if (c && !r && !wprev) begin
            pal1[a] = d[11:0];
            pal0[a] = d[11:0] & 12'h777;
        end
        wprev = c & ~r;
        @(posedge clk32);
        @(negedge clk32);
        chk("ste1_out", {3'b0, r1, g1, b1, m1, dout1}, {3'b0, exp1, edout1});
        chk("ste0_out", {3'b0, r0, g0, b0, m0, dout0}, {3'b0, exp0, edout0});
    endtask

    // Reset mid-stream with a write strobe already asserted.
    task automatic do_reset();
        cs = 1'b1; rw = 1'b0; addr = 4'd4; din = 16'h0FFF;
        reset = 1'b1;
        #1;
        chk("rst_async_ste1", {3'b0, r1, g1, b1, m1, dout1}, 32'h0);
        chk("rst_async_ste0", {3'b0, r0, g0, b0, m0, dout0}, 32'h0);
        model_reset();
        @(posedge clk32);
        @(negedge clk32);
        reset = 1'b0;
    endtask

    logic rc, rr, ren, rbl;
    logic [1:0] rrz;
    logic [3:0] rci, ra;

    initial begin
        reset = 1'b1; pixClkEn = 1'b0; rez = 2'b00; color_index = 4'h0;
        BLANK_n = 1'b0; cs = 1'b0; rw = 1'b1; addr = 4'h0; din = 16'h0;
        model_reset();
        @(negedge clk32);
        chk("reset_state", {3'b0, r1, g1, b1, m1, dout1, r0, g0, b0, m0} , 32'h0);
        reset = 1'b0;

        // Read after reset, then write $0F5A to entry 3. din[15:12] is junk.
        step(0, 2'b00, 4'h0, 1, 1, 1, 4'd9, 16'h0);
        chk("rd_after_rst", {16'h0, dout1}, 32'h0);
        step(0, 2'b00, 4'h0, 1, 0, 1, 4'd0, 16'h0);
        step(0, 2'b00, 4'h0, 1, 1, 0, 4'd3, 16'hAF5A);
        step(0, 2'b00, 4'h0, 1, 0, 1, 4'd3, 16'h0);
        step(0, 2'b00, 4'h0, 1, 1, 1, 4'd3, 16'h0);
        chk("rd3_ste1", {16'h0, dout1}, 32'h0F5A);
        chk("rd3_ste0", {16'h0, dout0}, 32'h0752);
        step(0, 2'b00, 4'h0, 1, 0, 1, 4'd0, 16'h0);

        // Look up index 3; it appears two enables later.
        step(1, 2'b00, 4'h3, 1, 0, 1, 4'd0, 16'h0);
        step(1, 2'b00, 4'h3, 1, 0, 1, 4'd0, 16'h0);
        chk("pix3_ste1", {20'h0, r1, g1, b1}, 32'hFA5);

        // Hold the write strobe for 10 cycles while din changes.
        for (int i = 0; i < 10; i++)
            step(1, 2'b00, 4'h5, 1, 1, 0, 4'd5, (i == 0) ? 16'h0FFF : 16'h0120 + 16'(i));
        step(1, 2'b00, 4'h5, 1, 0, 1, 4'd5, 16'h0);
        step(1, 2'b00, 4'h5, 1, 1, 1, 4'd5, 16'h0);
        chk("rd5_ste0", {16'h0, dout0}, 32'h0777);
        chk("pix5_ste0", {20'h0, r0, g0, b0}, 32'hFFF);

        // Mono mode.
        step(0, 2'b10, 4'h1, 1, 1, 0, 4'd0, 16'h0000);
        step(1, 2'b10, 4'h1, 1, 0, 1, 4'd0, 16'h0);
        step(1, 2'b10, 4'h1, 1, 0, 1, 4'd0, 16'h0);
        chk("mono_white", {19'h0, r1, g1, b1, m1}, 32'h1FFF);
        step(0, 2'b10, 4'h1, 1, 1, 0, 4'd0, 16'h0001);
        step(0, 2'b10, 4'h1, 1, 0, 1, 4'd0, 16'h0);
        step(1, 2'b11, 4'h1, 1, 0, 1, 4'd0, 16'h0);
        chk("mono_black", {19'h0, r1, g1, b1, m1}, 32'h0);
        step(1, 2'b11, 4'h0, 1, 0, 1, 4'd0, 16'h0);

        // One blanked pixel, then the enable stops for 5 cycles.
        step(1, 2'b00, 4'h3, 1, 0, 1, 4'd0, 16'h0);
        step(1, 2'b00, 4'h3, 0, 0, 1, 4'd0, 16'h0);
        step(1, 2'b00, 4'h3, 1, 0, 1, 4'd0, 16'h0);
        chk("blank_px", {20'h0, r1, g1, b1}, 32'h0);
        step(1, 2'b00, 4'h3, 1, 0, 1, 4'd0, 16'h0);
        for (int i = 0; i < 5; i++)
            step(0, 2'b10, 4'(i), 0, 0, 1, 4'd0, 16'h0);
        chk("hold_px", {20'h0, r1, g1, b1}, 32'hFA5);

        // Collision on entry 7.
        step(0, 2'b00, 4'h7, 1, 1, 0, 4'd7, 16'h0123);
        step(1, 2'b00, 4'h7, 1, 0, 1, 4'd0, 16'h0);
        step(1, 2'b00, 4'h7, 1, 1, 0, 4'd7, 16'h0ABC);
        chk("collide_old", {20'h0, r1, g1, b1}, 32'h246);
        step(1, 2'b00, 4'h7, 1, 0, 1, 4'd0, 16'h0);
        chk("collide_new", {20'h0, r1, g1, b1}, 32'h579);

        // Reset is released with a strobe already high, so no write occurs.
        do_reset();
        step(1, 2'b00, 4'h4, 1, 1, 0, 4'd4, 16'h0FFF);
        step(1, 2'b00, 4'h4, 1, 1, 0, 4'd4, 16'h0FFF);
        step(1, 2'b00, 4'h4, 1, 1, 1, 4'd4, 16'h0);
        chk("no_wr_after_rst", {16'h0, dout1}, 32'h0);

        // Randomized traffic.
        rc = 1'b0; rr = 1'b1; ra = 4'h0; rrz = 2'b00;
        for (int i = 0; i < 800; i++) begin
            if (i == 400) begin
                do_reset();
                rc = 1'b1; rr = 1'b0; ra = 4'd4;
            end
            if ($urandom_range(0, 3) == 0) begin
                rc = ~rc;
                if (rc) begin
                    rr = 1'($urandom_range(0, 1));
                    ra = 4'($urandom_range(0, 15));
                end
            end
            if ($urandom_range(0, 31) == 0) rrz = 2'($urandom_range(0, 3));
            ren = ($urandom_range(0, 3) != 0);
            rbl = ($urandom_range(0, 7) != 0);
            rci = 4'($urandom_range(0, 15));
            step(ren, rrz, rci, rbl, rc, rr, ra, 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
